// File: rtl/echo_enq_arbiter.sv
// Round-robin arbiter sharing the echo FIFO enq method among NREQ rule drivers.
// One-entry holding register replays the granted value under fifo_enq__RDY.
module echo_enq_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req_enq__ENA,
  input  logic [NREQ*WIDTH-1:0]   req_enq_v,
  output logic [NREQ-1:0]         req_enq__RDY,
  output logic                    fifo_enq__ENA,
  output logic [WIDTH-1:0]        fifo_enq_v,
  input  logic                    fifo_enq__RDY,
  output logic [IDW-1:0]          fifo_src,
  output logic [31:0]             accept_count
);

  logic [IDW-1:0]   ptr_r;
  logic             buf_valid_r;
  logic [WIDTH-1:0] buf_data_r;
  logic [IDW-1:0]   buf_src_r;
  logic [31:0]      cnt_r;

  logic             drain_s;
  logic             space_s;
  logic             found_s;
  logic [IDW-1:0]   win_s;
  logic [WIDTH-1:0] win_data_s;
  logic [NREQ-1:0]  grant_s;
  logic             accept_s;
  logic [IDW-1:0]   ptr_nxt_s;

  // Requester index visited k steps after the round-robin start point.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
    return IDW'((int'(p) + k) % NREQ);
  endfunction

  assign drain_s       = buf_valid_r & fifo_enq__RDY;
  assign space_s       = ~buf_valid_r | drain_s;
  assign fifo_enq__ENA = drain_s;
  assign fifo_enq_v    = buf_data_r;
  assign fifo_src      = buf_src_r;
  assign accept_count  = cnt_r;
  assign req_enq__RDY  = grant_s;

  // Winner search: first asserted request at or after ptr, wrapping.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && req_enq__ENA[rr_idx(ptr_r, k)]) begin
        found_s = 1'b1;
        win_s   = rr_idx(ptr_r, k);
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant and winner data mux; grants are suppressed while in reset.
  always_comb begin
    grant_s    = '0;
    win_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_s == IDW'(i)) begin
        grant_s[i] = found_s & space_s & ~RST;
        win_data_s = req_enq_v[i*WIDTH +: WIDTH];
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  assign accept_s  = |grant_s;
  assign ptr_nxt_s = (win_s == IDW'(NREQ - 1)) ? '0 : (win_s + IDW'(1));

  // Holding register, round-robin pointer and accept counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_r       <= '0;
      buf_valid_r <= 1'b0;
      buf_data_r  <= '0;
      buf_src_r   <= '0;
      cnt_r       <= 32'd0;
    end else begin
      if (accept_s) begin
        buf_data_r  <= win_data_s;
        buf_src_r   <= win_s;
        buf_valid_r <= 1'b1;
        ptr_r       <= ptr_nxt_s;
        cnt_r       <= cnt_r + 32'd1;
      end else if (drain_s) begin
        buf_valid_r <= 1'b0;
      end else begin
        buf_valid_r <= buf_valid_r;
      end
    end
  end

endmodule
